multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle RV32 core; producer side of the aluop interface.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction from ir_opcode and emits
//  datapath strobes plus aluop[1:0] (00=ADD addr/PC+4, 01=SUB branch cmp, 10=R-type by funct).
//  Stalls on a single-outstanding memory ready handshake.
// PARAMETERS
//  INSTRET_W  32  width of retired-instruction counter (only with MCCTRL_PERF_EN)
// PORTS
//  clk            in   1   core clock; all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  ir_opcode      in   7   opcode field of the instruction register
//  mem_ready      in   1   memory completes current mem_read/mem_write this cycle
//  pc_write       out  1   unconditional PC load
//  pc_write_cond  out  1   PC load qualified by ALU zero (BEQ), ANDed in datapath
//  pc_source      out  2   00 ALU result, 01 ALUOut reg, 10 JAL target
//  iord           out  1   0 memory addr=PC, 1 addr=ALUOut
//  mem_read       out  1   memory read request, held until mem_ready
//  mem_write      out  1   memory write request, held until mem_ready
//  ir_write       out  1   load instruction register
//  reg_write      out  1   register file write enable
//  mem_to_reg     out  2   WB mux: 00 ALUOut, 01 MDR, 10 PC (link)
//  alu_src_a      out  1   0 PC/oldPC, 1 rs1
//  alu_src_b      out  2   00 rs2, 01 const 4, 10 imm
//  aluop          out  2   to ALU-control decoder (encoding above)
//  illegal_instr  out  1   sticky: unsupported opcode decoded
//  instret        out  INSTRET_W  retired count (port exists only with MCCTRL_PERF_EN)
// BEHAVIOUR
//  States: IDLE FETCH DECODE MEMADDR MEMRD MEMWR LWB EXEC RWB BRANCH JAL TRAP.
//  Reset: state=IDLE; every output 0; illegal_instr=0; instret=0. Reset mid-op aborts at once.
//  IDLE: outputs 0; -> FETCH unconditionally next cycle.
//  FETCH: mem_read=1 iord=0 alu_src_a=0 alu_src_b=01 aluop=00 pc_source=00; hold while
//    !mem_ready; when mem_ready: ir_write=1 and pc_write=1 same cycle (Mealy), -> DECODE.
//  DECODE: alu_src_a=0 alu_src_b=10 aluop=00 (branch target to ALUOut); branch on opcode:
//    0000011/0100011 ->MEMADDR, 0110011 ->EXEC, 1100011 ->BRANCH, 1101111 ->JAL, else ->TRAP.
//  MEMADDR: alu_src_a=1 alu_src_b=10 aluop=00; -> MEMRD (load) or MEMWR (store).
//  MEMRD: mem_read=1 iord=1; hold until mem_ready, then -> LWB.
//  MEMWR: mem_write=1 iord=1; hold until mem_ready, then -> FETCH (retire).
//  LWB: reg_write=1 mem_to_reg=01; -> FETCH (retire).
//  EXEC: alu_src_a=1 alu_src_b=00 aluop=10; -> RWB.   RWB: reg_write=1 mem_to_reg=00; -> FETCH (retire).
//  BRANCH: alu_src_a=1 alu_src_b=00 aluop=01 pc_write_cond=1 pc_source=01; -> FETCH (retire).
//  JAL: reg_write=1 mem_to_reg=10 pc_write=1 pc_source=10; -> FETCH (retire).
//  TRAP: illegal_instr=1, all strobes 0; terminal until rst_n low.
//  Zero-wait latency: R 4, load 5, store 4, branch 3, JAL 3 cycles; +1 per wait cycle.
//  mem_read and mem_write never both 1; requests stable until mem_ready (no retract).
//  Unlisted outputs in any state are 0; DECODE opcode sampled only in DECODE.
// CONFIGURATION
//  MCCTRL_PERF_EN defined: instret port present, +1 (wrapping) on every retire transition
//    into FETCH; reset to 0. Undefined: no counter, no instret port; FSM identical.
// STRUCTURE
//  Package riscv_ctrl_pkg: state_t enum, OPC_* opcode constants, ALUOP_ADD/SUB/RTYPE,
//    PCSRC_*, WBSEL_*, ALUB_* encodings. Shared with alu control decoder and datapath.
//  Single module; outputs decoded combinationally from state (+mem_ready), state in one always_ff.
// TESTING
//  1 rst_n low mid-MEMRD, release -> all outputs 0, IDLE then FETCH next cycle, mem_read=1.
//  2 R-type 0110011, mem_ready=1 -> FETCH,DECODE,EXEC(aluop=10),RWB(reg_write) in 4 cycles.
//  3 Load 0000011, mem_ready low 2 cycles in MEMRD -> mem_read,iord held 3 cycles, LWB mem_to_reg=01, 7 total.
//  4 Branch 1100011 -> BRANCH cycle aluop=01 pc_write_cond=1 pc_source=01; 3 cycles.
//  5 Opcode 1111111 -> TRAP, illegal_instr=1 held 20 cycles, no strobes, mem_ready ignored.
//  6 MCCTRL_PERF_EN: 3 R-type + 1 store, zero wait -> instret=4 after 16 cycles; preload FFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control path: FSM states, opcodes,
// ALU-op, PC-source, write-back and ALU-B mux selects.
package riscv_ctrl_pkg;

    localparam int unsigned OPC_W    = 7;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned PCSRC_W  = 2;
    localparam int unsigned WBSEL_W  = 2;
    localparam int unsigned ALUB_W   = 2;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADDR = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_LWB     = 4'd6,
        ST_EXEC    = 4'd7,
        ST_RWB     = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JAL     = 4'd10,
        ST_TRAP    = 4'd11
    } state_t;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JAL    = 2'b10;

    localparam logic [WBSEL_W-1:0] WBSEL_ALUOUT = 2'b00;
    localparam logic [WBSEL_W-1:0] WBSEL_MDR    = 2'b01;
    localparam logic [WBSEL_W-1:0] WBSEL_PC     = 2'b10;

    localparam logic [ALUB_W-1:0] ALUB_RS2  = 2'b00;
    localparam logic [ALUB_W-1:0] ALUB_FOUR = 2'b01;
    localparam logic [ALUB_W-1:0] ALUB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32 core. Define MCCTRL_PERF_EN to add
// the retired-instruction counter port instret.
module multicycle_control
    import riscv_ctrl_pkg::*;
`ifdef MCCTRL_PERF_EN
#(
    parameter int unsigned INSTRET_W = 32
)
`endif
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   ir_opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [PCSRC_W-1:0] pc_source,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [WBSEL_W-1:0] mem_to_reg,
    output logic               alu_src_a,
    output logic [ALUB_W-1:0]  alu_src_b,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal_instr
`ifdef MCCTRL_PERF_EN
    ,
    output logic [INSTRET_W-1:0] instret
`endif
);

    state_t state;
    state_t state_nxt;
    logic   is_store;

    // The load/store choice is captured in DECODE so MEMADDR never looks at the opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            is_store <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                is_store <= (ir_opcode == OPC_STORE);
            end
        end
    end

    // Next state and datapath strobes; FETCH completion is Mealy on mem_ready.
    always_comb begin
        state_nxt     = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = WBSEL_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_RS2;
        aluop         = ALUOP_ADD;
        illegal_instr = 1'b0;

        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = ALUB_IMM;
                case (ir_opcode)
                    OPC_LOAD, OPC_STORE: state_nxt = ST_MEMADDR;
                    OPC_RTYPE:           state_nxt = ST_EXEC;
                    OPC_BRANCH:          state_nxt = ST_BRANCH;
                    OPC_JAL:             state_nxt = ST_JAL;
                    default:             state_nxt = ST_TRAP;
                endcase
            end
            ST_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_nxt = is_store ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_nxt = ST_LWB;
            end
            ST_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_nxt = ST_FETCH;
            end
            ST_LWB: begin
                reg_write  = 1'b1;
                mem_to_reg = WBSEL_MDR;
                state_nxt  = ST_FETCH;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_RS2;
                aluop     = ALUOP_RTYPE;
                state_nxt = ST_RWB;
            end
            ST_RWB: begin
                reg_write  = 1'b1;
                mem_to_reg = WBSEL_ALUOUT;
                state_nxt  = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALUB_RS2;
                aluop         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_nxt     = ST_FETCH;
            end
            ST_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = WBSEL_PC;
                pc_write   = 1'b1;
                pc_source  = PCSRC_JAL;
                state_nxt  = ST_FETCH;
            end
            ST_TRAP: illegal_instr = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef MCCTRL_PERF_EN
    logic retire;

    // A retire is any entry into FETCH other than the post-reset IDLE step or a FETCH stall.
    assign retire = (state_nxt == ST_FETCH) && (state != ST_FETCH) && (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + INSTRET_W'(1);
        end
    end
`endif

endmodule
